ghost_waypoint_sequencer: RTL and testbench
===========================================

// Module: ghost_waypoint_sequencer
// PURPOSE
// Direction-command initiator for a ghost mover. Each frame it compares the ghost's
// position against an external waypoint table and emits a WASD keycode
// (04 left, 07 right, 16 down, 1A up) when a waypoint window is entered.
// It then steps through the table circularly.
// It sits between the waypoint ROM and the ghost movement block, replacing
// hard-coded per-ghost waypoint ladders.
// PARAMETERS
// N_WP        27  number of table entries, valid range 2..32
// IDX_W       5   width of wp_idx, must satisfy 2**IDX_W >= N_WP
// WIN         2   capture half-window in pixels, per axis, inclusive
// STALL_LIMIT 64  frames with an unchanged position in SEEK before a stall is declared
// PORTS
// frame_clk  in   1      frame-rate clock; all state changes on its rising edge
// Reset      in   1      synchronous, active-high
// enable     in   1      run the sequencer; low freezes it in IDLE
// ghost_x    in   10     current ghost X position
// ghost_y    in   10     current ghost Y position
// wp_x       in   10     table X for entry wp_idx; combinational read, valid same cycle
// wp_y       in   10     table Y for entry wp_idx
// wp_dir     in   8      keycode to issue at entry wp_idx
// wp_idx     out  IDX_W  current table index
// keycode    out  8      registered direction command; 8'h00 when idle
// cmd_valid  out  1      one-cycle pulse, coincident with a non-zero keycode
// lap_done   out  1      one-cycle pulse when wp_idx wraps from N_WP-1 to 0
// stalled    out  1      stall indicator; see CONFIGURATION
// BEHAVIOUR
// - Reset: state=IDLE, wp_idx=0, keycode=8'h00, cmd_valid=0, lap_done=0, stalled=0,
//   stall_cnt=0, hold_x=0, hold_y=0. Reset wins over every other event.
// - hit = (|ghost_x-wp_x| <= WIN) && (|ghost_y-wp_y| <= WIN).
//   - Each difference is computed as larger minus smaller, 10-bit unsigned. No wrap.
// - IDLE: when enable=1, go to SEEK next cycle. wp_idx is retained; no reset on re-enable.
// - SEEK:
//   - If hit, go to ISSUE.
//   - Otherwise stall_cnt increments when ghost_x/ghost_y equal last frame's value,
//     and clears when they differ.
// - ISSUE (exactly 1 cycle):
//   - keycode<=wp_dir, cmd_valid<=1.
//   - Latch hold_x/hold_y<=wp_x/wp_y.
//   - wp_idx<=wp_idx+1, or 0 if wp_idx==N_WP-1; on that wrap lap_done<=1.
//   - stall_cnt<=0. Go to HOLD.
// - HOLD:
//   - keycode<=8'h00, cmd_valid<=0.
//   - Stay while the ghost is inside the WIN window around hold_x/hold_y.
//   - Leave to SEEK on the first frame outside it. This prevents double-issue.
// - A table entry whose window overlaps the previous one is matched only after HOLD exits.
// - Latency: ghost enters window at edge k -> keycode/cmd_valid visible after edge k+1.
// - keycode and cmd_valid are high for exactly one cycle per issue.
// - lap_done is high for exactly one cycle per wrap.
// - enable=0 in any state: next cycle go to IDLE, keycode=00, cmd_valid=0, stall_cnt=0.
//   - An in-flight ISSUE still completes if enable drops in the same cycle.
// - wp_dir not in {04,07,16,1A}: issued unchanged. Validating it is the mover's concern.
// - Stall: stall_cnt saturates at STALL_LIMIT. Reaching it triggers the stall action.
// CONFIGURATION
// Macro GHOST_SEQ_STALL_RETRY_EN.
// - Defined:
//   - On stall, re-issue the last issued keycode for one cycle, with cmd_valid=1.
//   - Pulse stalled for 1 cycle, clear stall_cnt, stay in SEEK.
//   - wp_idx is unchanged.
//   - If no keycode has been issued since Reset, issue wp_dir instead.
// - Undefined:
//   - On stall, stalled goes high and stays high until Reset.
//   - No command is issued; sequencing continues normally.
// TESTING
// - Reset, enable=1, ghost at (176,64), table[0]=(176,64,16):
//   keycode=16 and cmd_valid=1 one cycle after SEEK; wp_idx=1.
// - Ghost held at (177,65) for 10 frames after issue:
//   no further cmd_valid; HOLD is left when the ghost reaches (176,67).
// - N_WP=3, walk the ghost through all 3 windows:
//   lap_done pulses with the third issue; wp_idx returns to 0.
// - Ghost frozen at (300,300) with no hit for 64 frames:
//   with macro, stalled and cmd_valid pulse on frame 64 and repeat the last keycode;
//   without macro, stalled stays 1 until Reset.
// - enable dropped in HOLD with wp_idx=4, raised 5 frames later:
//   keycode=00 throughout; SEEK resumes at wp_idx=4.
// - Reset asserted in the same cycle as a hit: all outputs at reset values; no cmd_valid.

Source files
------------

// File: rtl/ghost_waypoint_sequencer.sv
// Waypoint-driven direction command sequencer for a ghost mover.
// Optional stall-retry behaviour is enabled by defining GHOST_SEQ_STALL_RETRY_EN.
module ghost_waypoint_sequencer #(
    parameter int unsigned N_WP        = 27,
    parameter int unsigned IDX_W       = 5,
    parameter int unsigned WIN         = 2,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             enable,
    input  logic [9:0]       ghost_x,
    input  logic [9:0]       ghost_y,
    input  logic [9:0]       wp_x,
    input  logic [9:0]       wp_y,
    input  logic [7:0]       wp_dir,
    output logic [IDX_W-1:0] wp_idx,
    output logic [7:0]       keycode,
    output logic             cmd_valid,
    output logic             lap_done,
    output logic             stalled
);

    localparam int unsigned      CntW      = $clog2(STALL_LIMIT + 1);
    localparam logic [9:0]       Win10     = 10'(WIN);
    localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(N_WP - 1);
    localparam logic [CntW-1:0]  StallMax  = CntW'(STALL_LIMIT);
    localparam logic [CntW-1:0]  StallLast = CntW'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {StIdle, StSeek, StIssue, StHold} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       key_q, key_d;
    logic             cmd_q, cmd_d;
    logic             lap_q, lap_d;
    logic             stalled_q, stalled_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [9:0]       hold_x_q, hold_x_d, hold_y_q, hold_y_d;
    logic [9:0]       prev_x_q, prev_y_q;
`ifdef GHOST_SEQ_STALL_RETRY_EN
    logic [7:0]       last_key_q, last_key_d;
    logic             issued_q, issued_d;
`endif

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic hit, in_hold, same_pos;
    assign hit      = (abs_diff(ghost_x, wp_x) <= Win10) && (abs_diff(ghost_y, wp_y) <= Win10);
    assign in_hold  = (abs_diff(ghost_x, hold_x_q) <= Win10) &&
                      (abs_diff(ghost_y, hold_y_q) <= Win10);
    assign same_pos = (ghost_x == prev_x_q) && (ghost_y == prev_y_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        key_d    = 8'h00;
        cmd_d    = 1'b0;
        lap_d    = 1'b0;
        cnt_d    = cnt_q;
        hold_x_d = hold_x_q;
        hold_y_d = hold_y_q;
`ifdef GHOST_SEQ_STALL_RETRY_EN
        stalled_d  = 1'b0;
        last_key_d = last_key_q;
        issued_d   = issued_q;
`else
        stalled_d  = stalled_q;
`endif
        if (!enable) begin
            // An issue already registered stays visible for its one cycle
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StSeek;
                StSeek: begin
                    if (hit) begin
                        state_d  = StIssue;
                        key_d    = wp_dir;
                        cmd_d    = 1'b1;
                        hold_x_d = wp_x;
                        hold_y_d = wp_y;
                        cnt_d    = '0;
`ifdef GHOST_SEQ_STALL_RETRY_EN
                        last_key_d = wp_dir;
                        issued_d   = 1'b1;
`endif
                        if (idx_q == LastIdx) begin
                            idx_d = '0;
                            lap_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else if (same_pos) begin
`ifdef GHOST_SEQ_STALL_RETRY_EN
                        if (cnt_q == StallLast) begin
                            cnt_d      = '0;
                            stalled_d  = 1'b1;
                            cmd_d      = 1'b1;
                            key_d      = issued_q ? last_key_q : wp_dir;
                            last_key_d = key_d;
                            issued_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
`else
                        if (cnt_q != StallMax) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (cnt_q == StallLast) begin
                            stalled_d = 1'b1;
                        end
`endif
                    end else begin
                        cnt_d = '0;
                    end
                end
                StIssue: state_d = StHold;
                StHold:  if (!in_hold) state_d = StSeek;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            key_q     <= 8'h00;
            cmd_q     <= 1'b0;
            lap_q     <= 1'b0;
            stalled_q <= 1'b0;
            cnt_q     <= '0;
            hold_x_q  <= '0;
            hold_y_q  <= '0;
            prev_x_q  <= '0;
            prev_y_q  <= '0;
`ifdef GHOST_SEQ_STALL_RETRY_EN
            last_key_q <= 8'h00;
            issued_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            cmd_q     <= cmd_d;
            lap_q     <= lap_d;
            stalled_q <= stalled_d;
            cnt_q     <= cnt_d;
            hold_x_q  <= hold_x_d;
            hold_y_q  <= hold_y_d;
            prev_x_q  <= ghost_x;
            prev_y_q  <= ghost_y;
`ifdef GHOST_SEQ_STALL_RETRY_EN
            last_key_q <= last_key_d;
            issued_q   <= issued_d;
`endif
        end
    end

    assign wp_idx    = idx_q;
    assign keycode   = key_q;
    assign cmd_valid = cmd_q;
    assign lap_done  = lap_q;
    assign stalled   = stalled_q;

endmodule

// File: tb/tb_ghost_waypoint_sequencer.sv
// Directed bench for ghost_waypoint_sequencer: a 27-entry instance and a 3-entry lap instance.
module tb_ghost_waypoint_sequencer;

    logic frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    logic       Reset, enable;
    logic [9:0] ghost_x, ghost_y;

    logic [9:0] tab_x [32];
    logic [9:0] tab_y [32];
    logic [7:0] tab_d [32];
    logic [9:0] wp_x, wp_y;
    logic [7:0] wp_dir, keycode;
    logic [4:0] wp_idx;
    logic       cmd_valid, lap_done, stalled;

    logic [9:0] s_tab_x [4];
    logic [9:0] s_tab_y [4];
    logic [7:0] s_tab_d [4];
    logic [9:0] s_wp_x, s_wp_y;
    logic [7:0] s_wp_dir, s_keycode;
    logic [1:0] s_wp_idx;
    logic       s_cmd_valid, s_lap_done, s_stalled;

    assign wp_x     = tab_x[wp_idx];
    assign wp_y     = tab_y[wp_idx];
    assign wp_dir   = tab_d[wp_idx];
    assign s_wp_x   = s_tab_x[s_wp_idx];
    assign s_wp_y   = s_tab_y[s_wp_idx];
    assign s_wp_dir = s_tab_d[s_wp_idx];

    ghost_waypoint_sequencer dut (
        .frame_clk(frame_clk), .Reset(Reset), .enable(enable),
        .ghost_x(ghost_x), .ghost_y(ghost_y),
        .wp_x(wp_x), .wp_y(wp_y), .wp_dir(wp_dir),
        .wp_idx(wp_idx), .keycode(keycode), .cmd_valid(cmd_valid),
        .lap_done(lap_done), .stalled(stalled)
    );

    ghost_waypoint_sequencer #(.N_WP(3), .IDX_W(2)) dut_lap (
        .frame_clk(frame_clk), .Reset(Reset), .enable(enable),
        .ghost_x(ghost_x), .ghost_y(ghost_y),
        .wp_x(s_wp_x), .wp_y(s_wp_y), .wp_dir(s_wp_dir),
        .wp_idx(s_wp_idx), .keycode(s_keycode), .cmd_valid(s_cmd_valid),
        .lap_done(s_lap_done), .stalled(s_stalled)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; enable = 1'b0; ghost_x = 10'd300; ghost_y = 10'd300;
        tick(); tick();
        n_cmp++; if (wp_idx !== 5'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", wp_idx); end
        n_cmp++; if (keycode !== 8'h00) begin n_bad++; $display("FAIL reset_key got %h want 00", keycode); end
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cmd got %b want 0", cmd_valid); end
        n_cmp++; if (lap_done !== 1'b0) begin n_bad++; $display("FAIL reset_lap got %b want 0", lap_done); end
        n_cmp++; if (stalled !== 1'b0) begin n_bad++; $display("FAIL reset_stalled got %b want 0", stalled); end
        Reset = 1'b0;
    endtask

    task automatic test_first_issue();
        ghost_x = 10'd176; ghost_y = 10'd64; enable = 1'b1;
        tick();
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL idle_to_seek_cmd got %b want 0", cmd_valid); end
        tick();
        n_cmp++; if (keycode !== 8'h16) begin n_bad++; $display("FAIL first_key got %h want 16", keycode); end
        n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("FAIL first_cmd got %b want 1", cmd_valid); end
        n_cmp++; if (wp_idx !== 5'd1) begin n_bad++; $display("FAIL first_idx got %0d want 1", wp_idx); end
    endtask

    task automatic test_hold();
        ghost_x = 10'd177; ghost_y = 10'd65;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (cmd_valid !== 1'b0 || keycode !== 8'h00) begin
                n_bad++; $display("FAIL hold_frame%0d got cmd=%b key=%h want cmd=0 key=00", i, cmd_valid, keycode);
            end
        end
        ghost_x = 10'd176; ghost_y = 10'd67;
        tick();
        ghost_x = 10'd100; ghost_y = 10'd100;
        tick();
        n_cmp++; if (keycode !== 8'h07 || cmd_valid !== 1'b1) begin
            n_bad++; $display("FAIL hold_exit_issue got key=%h cmd=%b want key=07 cmd=1", keycode, cmd_valid); end
        n_cmp++; if (wp_idx !== 5'd2) begin n_bad++; $display("FAIL hold_exit_idx got %0d want 2", wp_idx); end
    endtask

    task automatic test_back_to_back();
        tick();
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL pulse_width got %b want 0", cmd_valid); end
        ghost_x = 10'd200; ghost_y = 10'd100;
        tick(); tick();
        n_cmp++; if (keycode !== 8'h1A || wp_idx !== 5'd3) begin
            n_bad++; $display("FAIL walk_1A got key=%h idx=%0d want key=1a idx=3", keycode, wp_idx); end
        ghost_x = 10'd200; ghost_y = 10'd200;
        tick(); tick(); tick();
        n_cmp++; if (keycode !== 8'h04 || cmd_valid !== 1'b1 || wp_idx !== 5'd4) begin
            n_bad++; $display("FAIL walk_04 got key=%h cmd=%b idx=%0d want key=04 cmd=1 idx=4",
                              keycode, cmd_valid, wp_idx); end
        tick();
    endtask

    task automatic test_enable_drop();
        enable = 1'b0; ghost_x = 10'd50; ghost_y = 10'd50;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (keycode !== 8'h00 || cmd_valid !== 1'b0 || wp_idx !== 5'd4) begin
                n_bad++; $display("FAIL disabled_frame%0d got key=%h cmd=%b idx=%0d want key=00 cmd=0 idx=4",
                                  i, keycode, cmd_valid, wp_idx); end
        end
        enable = 1'b1;
        tick();
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reenable_seek got %b want 0", cmd_valid); end
        tick();
        n_cmp++; if (keycode !== 8'h16 || cmd_valid !== 1'b1 || wp_idx !== 5'd5) begin
            n_bad++; $display("FAIL resume_idx4 got key=%h cmd=%b idx=%0d want key=16 cmd=1 idx=5",
                              keycode, cmd_valid, wp_idx); end
    endtask

    task automatic test_stall();
        ghost_x = 10'd300; ghost_y = 10'd300;
        tick(); tick();
        repeat (63) tick();
        n_cmp++; if (stalled !== 1'b0 || cmd_valid !== 1'b0) begin
            n_bad++; $display("FAIL stall_early got stalled=%b cmd=%b want 0 0", stalled, cmd_valid); end
        tick();
`ifdef GHOST_SEQ_STALL_RETRY_EN
        n_cmp++; if (stalled !== 1'b1 || cmd_valid !== 1'b1 || keycode !== 8'h16) begin
            n_bad++; $display("FAIL stall_retry got stalled=%b cmd=%b key=%h want 1 1 16",
                              stalled, cmd_valid, keycode); end
        tick();
        n_cmp++; if (stalled !== 1'b0 || cmd_valid !== 1'b0) begin
            n_bad++; $display("FAIL stall_pulse got stalled=%b cmd=%b want 0 0", stalled, cmd_valid); end
`else
        n_cmp++; if (stalled !== 1'b1 || cmd_valid !== 1'b0) begin
            n_bad++; $display("FAIL stall_flag got stalled=%b cmd=%b want 1 0", stalled, cmd_valid); end
        repeat (5) tick();
        n_cmp++; if (stalled !== 1'b1) begin n_bad++; $display("FAIL stall_sticky got %b want 1", stalled); end
`endif
        n_cmp++; if (wp_idx !== 5'd5) begin n_bad++; $display("FAIL stall_idx got %0d want 5", wp_idx); end
    endtask

    task automatic test_reset_hit();
        ghost_x = 10'd500; ghost_y = 10'd500; Reset = 1'b1;
        tick();
        n_cmp++; if (cmd_valid !== 1'b0 || keycode !== 8'h00 || wp_idx !== 5'd0) begin
            n_bad++; $display("FAIL reset_hit got cmd=%b key=%h idx=%0d want 0 00 0", cmd_valid, keycode, wp_idx); end
        n_cmp++; if (stalled !== 1'b0 || lap_done !== 1'b0) begin
            n_bad++; $display("FAIL reset_hit_flags got stalled=%b lap=%b want 0 0", stalled, lap_done); end
        Reset = 1'b0;
        tick();
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_cmd got %b want 0", cmd_valid); end
    endtask

    task automatic test_lap();
        ghost_x = 10'd400; ghost_y = 10'd400;
        tick();
        n_cmp++; if (s_keycode !== 8'h04 || s_wp_idx !== 2'd1 || s_lap_done !== 1'b0) begin
            n_bad++; $display("FAIL lap_wp0 got key=%h idx=%0d lap=%b want 04 1 0", s_keycode, s_wp_idx, s_lap_done); end
        ghost_x = 10'd420;
        tick(); tick(); tick();
        n_cmp++; if (s_keycode !== 8'h07 || s_wp_idx !== 2'd2 || s_lap_done !== 1'b0) begin
            n_bad++; $display("FAIL lap_wp1 got key=%h idx=%0d lap=%b want 07 2 0", s_keycode, s_wp_idx, s_lap_done); end
        ghost_x = 10'd440;
        tick(); tick(); tick();
        n_cmp++; if (s_keycode !== 8'h16 || s_cmd_valid !== 1'b1 || s_wp_idx !== 2'd0 || s_lap_done !== 1'b1) begin
            n_bad++; $display("FAIL lap_wrap got key=%h cmd=%b idx=%0d lap=%b want 16 1 0 1",
                              s_keycode, s_cmd_valid, s_wp_idx, s_lap_done); end
        tick();
        n_cmp++; if (s_lap_done !== 1'b0) begin n_bad++; $display("FAIL lap_pulse got %b want 0", s_lap_done); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            tab_x[i] = 10'd500; tab_y[i] = 10'd500; tab_d[i] = 8'h04;
        end
        tab_x[0] = 10'd176; tab_y[0] = 10'd64;  tab_d[0] = 8'h16;
        tab_x[1] = 10'd100; tab_y[1] = 10'd100; tab_d[1] = 8'h07;
        tab_x[2] = 10'd200; tab_y[2] = 10'd100; tab_d[2] = 8'h1A;
        tab_x[3] = 10'd200; tab_y[3] = 10'd200; tab_d[3] = 8'h04;
        tab_x[4] = 10'd50;  tab_y[4] = 10'd50;  tab_d[4] = 8'h16;
        s_tab_x[0] = 10'd400; s_tab_y[0] = 10'd400; s_tab_d[0] = 8'h04;
        s_tab_x[1] = 10'd420; s_tab_y[1] = 10'd400; s_tab_d[1] = 8'h07;
        s_tab_x[2] = 10'd440; s_tab_y[2] = 10'd400; s_tab_d[2] = 8'h16;
        s_tab_x[3] = 10'd0;   s_tab_y[3] = 10'd0;   s_tab_d[3] = 8'h00;

        test_reset();
        test_first_issue();
        test_hold();
        test_back_to_back();
        test_enable_drop();
        test_stall();
        test_reset_hit();
        test_lap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
